// File: rtl/ram_pattern_writer_if.sv
// AXI4 write-only channel bundle used by ram_pattern_writer (AW, W, B).
interface ram_pattern_writer_if #(
   parameter int AXI_DATA_WIDTH = 512,
   parameter int AXI_ADDR_WIDTH = 34,
   parameter int AXI_ID_WIDTH   = 4
);
   logic [AXI_ADDR_WIDTH-1:0]   awaddr;
   logic                        awvalid;
   logic                        awready;
   logic [AXI_ID_WIDTH-1:0]     awid;
   logic [7:0]                  awlen;
   logic [2:0]                  awsize;
   logic [1:0]                  awburst;
   logic                        awlock;
   logic [3:0]                  awcache;
   logic [3:0]                  awqos;
   logic [2:0]                  awprot;
   logic [AXI_DATA_WIDTH-1:0]   wdata;
   logic [AXI_DATA_WIDTH/8-1:0] wstrb;
   logic                        wlast;
   logic                        wvalid;
   logic                        wready;
   logic [1:0]                  bresp;
   logic                        bvalid;
   logic                        bready;

   modport master (
      output awaddr, awvalid, awid, awlen, awsize, awburst, awlock, awcache, awqos, awprot,
      output wdata, wstrb, wlast, wvalid, bready,
      input  awready, wready, bresp, bvalid
   );

   modport slave (
      input  awaddr, awvalid, awid, awlen, awsize, awburst, awlock, awcache, awqos, awprot,
      input  wdata, wstrb, wlast, wvalid, bready,
      output awready, wready, bresp, bvalid
   );
endinterface

// File: rtl/ram_pattern_writer.sv
// Fills a DDR region with an incrementing 32-bit lane pattern using AXI4
// single-beat writes, one write outstanding at a time.
// Optional macro RAM_WRITER_PERF_EN adds the CYCLE_COUNT busy-cycle counter.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for START; DONE pulses here after the last word
// S_ISSUE | loads AWADDR/WDATA for the current word, raises valids
// S_XFER  | AW and W in flight; each valid drops on its own handshake
// S_RESP  | waiting for the B response of the current word
module ram_pattern_writer #(
   parameter int AXI_DATA_WIDTH = 512,
   parameter int AXI_ADDR_WIDTH = 34,
   parameter int AXI_ID_WIDTH   = 4,
   parameter int BLOCK_SIZE     = 256
) (
   input  logic                      M_AXI_ACLK,
   input  logic                      M_AXI_ARESETN,
   input  logic                      START,
   input  logic [AXI_ADDR_WIDTH-1:0] START_ADDR,
   output logic                      BUSY,
   output logic                      DONE,
   output logic [15:0]               ERR_COUNT,
`ifdef RAM_WRITER_PERF_EN
   output logic [31:0]               CYCLE_COUNT,
`endif
   ram_pattern_writer_if.master      m_axi
);

   localparam int LANES = AXI_DATA_WIDTH / 32;
   localparam int BYTES = AXI_DATA_WIDTH / 8;
   localparam int IDX_W = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;
   localparam logic [IDX_W-1:0]          LAST_IDX  = IDX_W'(BLOCK_SIZE - 1);
   localparam logic [AXI_ADDR_WIDTH-1:0] ADDR_STEP = AXI_ADDR_WIDTH'(BYTES);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_XFER, S_RESP} state_e;

   state_e                    state_q, state_d;
   logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [IDX_W-1:0]          index_q, index_d;
   logic                      awvalid_q, awvalid_d;
   logic                      wvalid_q, wvalid_d;
   logic                      bready_q, bready_d;
   logic                      busy_q, busy_d;
   logic                      done_q, done_d;
   logic [15:0]               err_q, err_d;
   logic [AXI_DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [AXI_DATA_WIDTH-1:0] pattern;
   logic [31:0]               idx32;

   logic aw_hs, w_hs, b_hs, xfer_done, last_word;

   assign aw_hs     = awvalid_q & m_axi.awready;
   assign w_hs      = wvalid_q & m_axi.wready;
   assign b_hs      = bready_q & m_axi.bvalid;
   // Both channels are finished once neither valid is still waiting after this edge.
   assign xfer_done = (!awvalid_q || aw_hs) && (!wvalid_q || w_hs);
   assign last_word = (index_q == LAST_IDX);
   assign idx32     = 32'(index_q);

   // Pattern for the current word: lane k holds index*LANES + k.
   always_comb begin
      pattern = '0;
      for (int k = 0; k < LANES; k++) begin
         pattern[k*32 +: 32] = idx32 * 32'(LANES) + 32'(k);
      end
   end

   // State register.
   always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
      if (!M_AXI_ARESETN) state_q <= S_IDLE;
      else                state_q <= state_d;
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (START) state_d = S_ISSUE;
         S_ISSUE: state_d = S_XFER;
         S_XFER:  if (xfer_done) state_d = S_RESP;
         S_RESP:  if (b_hs) state_d = last_word ? S_IDLE : S_ISSUE;
         default: state_d = S_IDLE;
      endcase
   end

   // Output and datapath next values.
   always_comb begin
      addr_d    = addr_q;
      index_d   = index_q;
      awvalid_d = awvalid_q;
      wvalid_d  = wvalid_q;
      bready_d  = bready_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      err_d     = err_q;
      wdata_d   = wdata_q;
      case (state_q)
         S_IDLE: begin
            if (START) begin
               addr_d  = START_ADDR;
               index_d = '0;
               err_d   = '0;
               busy_d  = 1'b1;
            end
         end
         S_ISSUE: begin
            wdata_d   = pattern;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            bready_d  = 1'b1;
         end
         S_XFER: begin
            if (aw_hs) awvalid_d = 1'b0;
            if (w_hs)  wvalid_d  = 1'b0;
         end
         S_RESP: begin
            if (b_hs) begin
               if (m_axi.bresp != 2'b00 && err_q != 16'hFFFF) err_d = err_q + 16'd1;
               if (last_word) begin
                  bready_d = 1'b0;
                  done_d   = 1'b1;
                  busy_d   = 1'b0;
               end else begin
                  index_d = index_q + IDX_W'(1);
                  addr_d  = addr_q + ADDR_STEP;
               end
            end
         end
         default: ;
      endcase
   end

   // Datapath and output registers.
   always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
      if (!M_AXI_ARESETN) begin
         addr_q    <= '0;
         index_q   <= '0;
         awvalid_q <= 1'b0;
         wvalid_q  <= 1'b0;
         bready_q  <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= '0;
         wdata_q   <= '0;
      end else begin
         addr_q    <= addr_d;
         index_q   <= index_d;
         awvalid_q <= awvalid_d;
         wvalid_q  <= wvalid_d;
         bready_q  <= bready_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         err_q     <= err_d;
         wdata_q   <= wdata_d;
      end
   end

`ifdef RAM_WRITER_PERF_EN
   logic [31:0] cyc_q, cyc_d;

   // Busy-cycle counter, cleared on an accepted START, saturating.
   always_comb begin
      cyc_d = cyc_q;
      if (state_q == S_IDLE && START)       cyc_d = '0;
      else if (busy_q && cyc_q != '1)       cyc_d = cyc_q + 32'd1;
   end

   // Busy-cycle counter register.
   always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
      if (!M_AXI_ARESETN) cyc_q <= '0;
      else                cyc_q <= cyc_d;
   end

   assign CYCLE_COUNT = cyc_q;
`endif

   assign BUSY      = busy_q;
   assign DONE      = done_q;
   assign ERR_COUNT = err_q;

   assign m_axi.awaddr  = addr_q;
   assign m_axi.awvalid = awvalid_q;
   assign m_axi.awid    = AXI_ID_WIDTH'(1);
   assign m_axi.awlen   = 8'd0;
   assign m_axi.awsize  = 3'($clog2(BYTES));
   assign m_axi.awburst = 2'b01;
   assign m_axi.awlock  = 1'b0;
   assign m_axi.awcache = 4'b0010;
   assign m_axi.awqos   = 4'd0;
   assign m_axi.awprot  = 3'd0;
   assign m_axi.wdata   = wdata_q;
   assign m_axi.wstrb   = '1;
   assign m_axi.wlast   = 1'b1;
   assign m_axi.wvalid  = wvalid_q;
   assign m_axi.bready  = bready_q;

endmodule

// File: tb/tb_ram_pattern_writer.sv
// Bench for ram_pattern_writer: AXI write slave with programmable ready/response
// delays, a table of directed fills, randomized fills and a mid-fill reset.
module tb_ram_pattern_writer;
   localparam int DW = 512;
   localparam int AW = 34;
   localparam int IW = 4;
   localparam int BS = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic          start;
   logic [AW-1:0] start_addr;
   logic          busy, done;
   logic [15:0]   err_count;
`ifdef RAM_WRITER_PERF_EN
   logic [31:0]   cycle_count;
`endif

   ram_pattern_writer_if #(.AXI_DATA_WIDTH(DW), .AXI_ADDR_WIDTH(AW), .AXI_ID_WIDTH(IW)) axi ();

   ram_pattern_writer #(
      .AXI_DATA_WIDTH(DW), .AXI_ADDR_WIDTH(AW), .AXI_ID_WIDTH(IW), .BLOCK_SIZE(BS)
   ) dut (
      .M_AXI_ACLK   (clk),
      .M_AXI_ARESETN(rst_n),
      .START        (start),
      .START_ADDR   (start_addr),
      .BUSY         (busy),
      .DONE         (done),
      .ERR_COUNT    (err_count),
`ifdef RAM_WRITER_PERF_EN
      .CYCLE_COUNT  (cycle_count),
`endif
      .m_axi        (axi)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Slave configuration and observed traffic.
   int            aw_dly = 0, w_dly = 0, b_dly = 0;
   logic [7:0]    br_cfg = 8'h00;
   logic [AW-1:0] aw_q[$];
   logic [DW-1:0] w_q[$];
   int            b_idx = 0;

   bit            aw_done, w_done, b_pending, prev_aw_wait, prev_w_wait;
   int            aw_cnt, w_cnt, b_wait;
   logic [AW-1:0] prev_awaddr;
   logic [DW-1:0] prev_wdata;

   // AXI write slave: decides readies at the falling edge for the coming rising edge.
   initial begin
      axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0; axi.bresp = 2'b00;
      forever begin
         @(negedge clk);
         axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0; axi.bresp = 2'b00;
         if (!rst_n) begin
            aw_done = 0; w_done = 0; b_pending = 0;
            aw_cnt = 0; w_cnt = 0; b_wait = 0;
            prev_aw_wait = 0; prev_w_wait = 0;
         end else begin
            if (prev_aw_wait) begin
               chk("aw_valid_held", axi.awvalid, 1);
               chk("aw_addr_stable", axi.awaddr, prev_awaddr);
            end
            if (prev_w_wait) begin
               chk("w_valid_held", axi.wvalid, 1);
               chk("w_data_stable", axi.wdata == prev_wdata, 1);
            end
            prev_aw_wait = 0; prev_w_wait = 0;
            if (b_pending) begin
               if (b_wait >= b_dly) begin
                  axi.bvalid = 1'b1;
                  axi.bresp  = br_cfg[2*(b_idx%4) +: 2];
                  if (axi.bready) begin
                     b_pending = 0;
                     b_idx++;
                  end
               end else b_wait++;
            end
            if (axi.awvalid) begin
               chk("aw_one_outstanding", {aw_done, b_pending}, 0);
               if (aw_cnt >= aw_dly) begin
                  axi.awready = 1'b1; aw_done = 1; aw_q.push_back(axi.awaddr);
               end else begin
                  aw_cnt++; prev_aw_wait = 1; prev_awaddr = axi.awaddr;
               end
            end
            if (axi.wvalid) begin
               chk("w_one_outstanding", {w_done, b_pending}, 0);
               if (w_cnt >= w_dly) begin
                  axi.wready = 1'b1; w_done = 1; w_q.push_back(axi.wdata);
               end else begin
                  w_cnt++; prev_w_wait = 1; prev_wdata = axi.wdata;
               end
            end
            if (aw_done && w_done) begin
               aw_done = 0; w_done = 0; aw_cnt = 0; w_cnt = 0;
               b_pending = 1; b_wait = 0;
            end
         end
      end
   end

   // One complete fill, checked against the reference model of the pattern.
   task automatic run_fill(input logic [AW-1:0] sa, input int awd, input int wd, input int bd,
                           input logic [7:0] br, input bit extra);
      int            cyc, exp_err, extra_done;
      logic [AW-1:0] ea;
      logic [DW-1:0] wtmp;
      aw_dly = awd; w_dly = wd; b_dly = bd; br_cfg = br;
      aw_q.delete(); w_q.delete(); b_idx = 0;
      exp_err = 0;
      for (int i = 0; i < BS; i++) if (br[2*i +: 2] != 2'b00) exp_err++;

      @(negedge clk); start = 1'b1; start_addr = sa;
      @(negedge clk); start = 1'b0; start_addr = AW'({$urandom, $urandom});
      chk("busy_after_start", busy, 1);
      chk("err_cleared", err_count, 0);
      chk("awvalid_issue", axi.awvalid, 0);
      @(negedge clk);
      chk("awvalid_rise", axi.awvalid, 1);
      chk("wvalid_rise", axi.wvalid, 1);
      chk("bready_rise", axi.bready, 1);
      cyc = 2;
      while (!done && cyc < 400) begin
         @(negedge clk); cyc++;
         start = extra && (cyc == 4 || cyc == 7);
      end
      start = 1'b0;
      chk("done_seen", done, 1);
      chk("busy_at_done", busy, 0);
      chk("err_at_done", err_count, exp_err);
      if (awd == 0 && wd == 0 && bd == 0) chk("done_latency", cyc, 13);
`ifdef RAM_WRITER_PERF_EN
      chk("cycle_count", cycle_count, cyc - 1);
`endif
      extra_done = 0;
      repeat (5) begin
         @(negedge clk);
         if (done) extra_done++;
      end
      chk("done_once", extra_done, 0);
      chk("busy_after", busy, 0);
`ifdef RAM_WRITER_PERF_EN
      chk("cycle_count_hold", cycle_count, cyc - 1);
`endif
      chk("aw_count", aw_q.size(), BS);
      chk("w_count", w_q.size(), BS);
      chk("b_count", b_idx, BS);
      for (int i = 0; i < BS; i++) begin
         ea = sa + AW'(i * (DW / 8));
         if (i < aw_q.size()) chk("aw_addr", aw_q[i], ea);
         if (i < w_q.size()) begin
            wtmp = w_q[i];
            for (int k = 0; k < DW / 32; k++)
               chk("w_lane", wtmp[k*32 +: 32], 32'(i * (DW / 32) + k));
         end
      end
   endtask

   typedef struct {
      logic [AW-1:0] sa;
      int            awd, wd, bd;
      logic [7:0]    br;
      bit            extra;
      logic [AW-1:0] exp_last;
      int            exp_err;
   } vec_t;

   vec_t          tbl[6];
   logic [DW-1:0] wsel;
   logic [AW-1:0] rsa;
   logic [31:0]   rv;
   int            t;

   initial begin
      tbl[0] = '{34'h0,           0, 0, 0, 8'h00, 1'b0, 34'h0C0,   0};
      tbl[1] = '{34'h1000,        0, 5, 0, 8'h00, 1'b0, 34'h10C0,  0};
      tbl[2] = '{34'h2000,        5, 0, 2, 8'h4C, 1'b1, 34'h20C0,  2};
      tbl[3] = '{34'h3000,        3, 3, 1, 8'h00, 1'b0, 34'h30C0,  0};
      tbl[4] = '{34'h40,          0, 0, 0, 8'h88, 1'b0, 34'h100,   2};
      tbl[5] = '{34'h3_FFFF_FF80, 1, 0, 0, 8'h00, 1'b1, 34'h40,    0};

      start = 1'b0; start_addr = '0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err_count, 0);
      chk("rst_awvalid", axi.awvalid, 0);
      chk("rst_wvalid", axi.wvalid, 0);
      chk("rst_bready", axi.bready, 0);
      chk("awlen", axi.awlen, 0);
      chk("awsize", axi.awsize, 6);
      chk("awburst", axi.awburst, 1);
      chk("awid", axi.awid, 1);
      chk("awcache", axi.awcache, 2);
      chk("wstrb", axi.wstrb, 64'hFFFF_FFFF_FFFF_FFFF);
      chk("wlast", axi.wlast, 1);
`ifdef RAM_WRITER_PERF_EN
      chk("rst_cycle_count", cycle_count, 0);
`endif
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 6; i++) begin
         run_fill(tbl[i].sa, tbl[i].awd, tbl[i].wd, tbl[i].bd, tbl[i].br, tbl[i].extra);
         chk("tbl_last_addr", (aw_q.size() == BS) ? aw_q[BS-1] : '1, tbl[i].exp_last);
         chk("tbl_err", err_count, tbl[i].exp_err);
         if (i == 0 && w_q.size() > 2) begin
            wsel = w_q[2];
            chk("word2_lane0", wsel[31:0], 32);
            chk("word2_lane15", wsel[511:480], 47);
         end
         if (i == 5 && aw_q.size() > 2) begin
            chk("wrap_addr1", aw_q[1], 34'h3_FFFF_FFC0);
            chk("wrap_addr2", aw_q[2], 34'h0);
         end
      end

      for (int r = 0; r < 12; r++) begin
         rv = $urandom;
         rsa = {2'($urandom_range(3, 0)), rv};
         rsa[5:0] = '0;
         run_fill(rsa, $urandom_range(4, 0), $urandom_range(4, 0), $urandom_range(4, 0),
                  8'($urandom), 1'($urandom_range(1, 0)));
      end

      // Reset in the middle of a transfer with AWVALID high.
      aw_dly = 8; w_dly = 8; b_dly = 0; br_cfg = 8'h00;
      aw_q.delete(); w_q.delete(); b_idx = 0;
      @(negedge clk); start = 1'b1; start_addr = 34'h500;
      @(negedge clk); start = 1'b0;
      t = 0;
      while (!axi.awvalid && t < 10) begin
         @(negedge clk); t++;
      end
      chk("xfer_awvalid", axi.awvalid, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_awvalid", axi.awvalid, 0);
      chk("async_wvalid", axi.wvalid, 0);
      chk("async_bready", axi.bready, 0);
      chk("async_busy", busy, 0);
`ifdef RAM_WRITER_PERF_EN
      chk("async_cycle_count", cycle_count, 0);
`endif
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("post_rst_awvalid", axi.awvalid, 0);
      chk("post_rst_busy", busy, 0);
      chk("post_rst_no_aw", aw_q.size(), 0);
      chk("post_rst_no_w", w_q.size(), 0);
      run_fill(34'h800, 1, 2, 1, 8'h00, 1'b1);
      chk("post_rst_err", err_count, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/ram_pattern_writer.md
Name: ram_pattern_writer

Overview:
- Fills DDR-RAM with a known incrementing pattern over AXI4 single-beat writes, started by one pulse.
- Sits directly upstream of the DDR read-back stage; that stage reads the same region and expects this pattern.
- Write-address, write-data and write-response channels only. The read channels are owned by the reader.

Parameters:
- AXI_DATA_WIDTH, 512, write data width in bits; must be a multiple of 32.
- AXI_ADDR_WIDTH, 34, byte address width.
- AXI_ID_WIDTH, 4, width of AWID.
- BLOCK_SIZE, 256, number of data words written per START; minimum 1.

Ports:
- M_AXI_ACLK  in  1  sole clock.
- M_AXI_ARESETN  in  1  reset, asynchronous, active-low.
- START  in  1  one-cycle pulse; begins a fill.
- START_ADDR  in  AXI_ADDR_WIDTH  base byte address, sampled on START; must be aligned to AXI_DATA_WIDTH/8.
- BUSY  out  1  high from the cycle after an accepted START until DONE.
- DONE  out  1  one-cycle pulse when the last B response is accepted.
- ERR_COUNT  out  16  number of B responses with BRESP!=0 in the current or last fill.
- M_AXI_AWADDR  out  AXI_ADDR_WIDTH; M_AXI_AWVALID out 1; M_AXI_AWREADY in 1.
- M_AXI_AWID out AXI_ID_WIDTH (=1); M_AXI_AWLEN out 8 (=0); M_AXI_AWSIZE out 3 (=log2(AXI_DATA_WIDTH/8)).
- M_AXI_AWBURST out 2 (=1); M_AXI_AWLOCK out 1 (=0); M_AXI_AWCACHE out 4 (=2); M_AXI_AWQOS out 4 (=0); M_AXI_AWPROT out 3 (=0).
- M_AXI_WDATA out AXI_DATA_WIDTH; M_AXI_WSTRB out AXI_DATA_WIDTH/8 (all ones); M_AXI_WLAST out 1 (=1).
- M_AXI_WVALID out 1; M_AXI_WREADY in 1.
- M_AXI_BRESP in 2; M_AXI_BVALID in 1; M_AXI_BREADY out 1.

Behaviour:
- Reset (async assert, sync release):
  - AWVALID=WVALID=BREADY=0, BUSY=0, DONE=0, ERR_COUNT=0, state=IDLE.
  - Reset mid-fill aborts immediately, with no further handshakes.
- FSM IDLE:
  - START=1 latches addr=START_ADDR and index=0, clears ERR_COUNT, then goes to ISSUE.
  - START while not IDLE is ignored.
- FSM ISSUE (entry cycle):
  - AWADDR=addr and WDATA=pattern(index).
  - AWVALID=1, WVALID=1, BREADY=1.
- FSM XFER:
  - Each VALID drops on its own handshake; AW and W may complete in either order or the same cycle.
  - Payloads stay stable while VALID is high.
  - Goes to RESP once both have completed, counting handshakes in the current cycle.
- FSM RESP:
  - On BVALID&BREADY: if BRESP!=0, ERR_COUNT increments, saturating at 16'hFFFF.
  - If index==BLOCK_SIZE-1: BREADY=0, DONE pulses one cycle, BUSY=0, go to IDLE.
  - Otherwise: index+1, addr+AXI_DATA_WIDTH/8 (wraps modulo 2^AXI_ADDR_WIDTH), go to ISSUE.
- Only one write is outstanding at a time; a new AW/W is never issued before the prior B is accepted.
- Pattern: 32-bit lane k (k=0..AXI_DATA_WIDTH/32-1) = index*(AXI_DATA_WIDTH/32)+k, truncated to 32 bits.
  - Example (512-bit): word 0 = lanes 0..15, word 1 = lanes 16..31.
- Latency: AWVALID/WVALID rise 2 cycles after START (IDLE→ISSUE→XFER registered outputs).
  - Minimum 3 cycles per word with zero-wait slave.
- BUSY=1 in every state except IDLE. DONE and BUSY=0 occur in the same cycle.

Optional Feature:
- RAM_WRITER_PERF_EN defined:
  - Adds output CYCLE_COUNT (32 bits), cleared on accepted START and incremented every cycle while BUSY; saturates at all-ones.
  - Holds its value after DONE until the next START; reset value 0.
- Undefined: port and counter absent, all other behaviour identical.

Test Plan:
- Zero-wait slave, START_ADDR=0, BLOCK_SIZE=4:
  - 4 writes to 0x00, 0x40, 0x80, 0xC0.
  - Word 2 lane 0 = 32, lane 15 = 47.
  - DONE pulses once; ERR_COUNT=0.
- WREADY delayed 5 cycles after AWREADY, then reversed order, then simultaneous:
  - Each word transferred exactly once; no second AW/W before B; data stable while VALID.
- Slave returns BRESP=2 on words 1 and 3 of 4: ERR_COUNT=2 at DONE.
  - Next START clears it to 0 on the cycle after START.
- START_ADDR=2^34-0x40, BLOCK_SIZE=2: addresses 0x3_FFFF_FFC0 then 0x0_0000_0000.
- Async reset asserted during XFER with AWVALID=1:
  - AWVALID/WVALID/BREADY/BUSY go 0 without a clock edge.
  - After release, a new START completes a full fill normally.
  - START pulses during BUSY cause no extra writes.
- With RAM_WRITER_PERF_EN, zero-wait slave, BLOCK_SIZE=4: CYCLE_COUNT=12 at DONE.
